// File: rtl/keypad_pkg.sv
// Shared types, the Pmod KYPD legend and width helpers for the keypad entry scanner.
package keypad_pkg;

  typedef enum logic [1:0] {NONE, KEY, MULTI} frame_result_t;
  typedef enum logic {IDLE, PRESSED} deb_state_t;

  // Row-major legend of the 4x4 Pmod KYPD: index = row*4 + col.
  localparam logic [3:0] PMOD_KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: candidate/counter tracking and the stable key state.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_stb_i,
  input  frame_result_t frame_res_i,
  input  logic [3:0]    frame_code_i,
  output logic          accept_o,
  output logic [3:0]    accept_code_o,
  output logic          held_o
);
  localparam int CW = cnt_w(DEBOUNCE_FRAMES);

  deb_state_t    state_q;
  logic [3:0]    stable_code_q;
  logic          cand_vld_q;
  logic          cand_key_q;
  logic [3:0]    cand_code_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          frm_key;
  logic          same;
  logic          differs;
  logic          commit;

  always_comb begin
    frm_key = (frame_res_i == KEY);
    same    = cand_vld_q && (cand_key_q == frm_key) &&
              (!frm_key || (cand_code_q == frame_code_i));
    if (!same)                              cnt_d = CW'(1);
    else if (cnt_q == CW'(DEBOUNCE_FRAMES)) cnt_d = cnt_q;
    else                                    cnt_d = cnt_q + CW'(1);
    differs = frm_key ? ((state_q == IDLE) || (stable_code_q != frame_code_i))
                      : (state_q == PRESSED);
    commit  = frame_stb_i && (frame_res_i != MULTI) &&
              (cnt_d == CW'(DEBOUNCE_FRAMES)) && differs;
  end

  // A release commits silently; only a new key produces an event.
  assign accept_o      = commit && frm_key;
  assign accept_code_o = frame_code_i;
  assign held_o        = (state_q == PRESSED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      stable_code_q <= 4'd0;
      cand_vld_q    <= 1'b0;
      cand_key_q    <= 1'b0;
      cand_code_q   <= 4'd0;
      cnt_q         <= '0;
    end else if (frame_stb_i) begin
      if (frame_res_i == MULTI) begin
        cnt_q      <= '0;
        cand_vld_q <= 1'b0;
      end else begin
        cand_vld_q  <= 1'b1;
        cand_key_q  <= frm_key;
        cand_code_q <= frame_code_i;
        cnt_q       <= cnt_d;
      end
      if (commit) begin
        state_q       <= frm_key ? PRESSED : IDLE;
        stable_code_q <= frame_code_i;
      end
    end
  end

endmodule

// File: rtl/keypad_entry_scanner.sv
// Matrix keypad scanner with frame debounce, hex digit buffer and entry count.
module keypad_entry_scanner
  import keypad_pkg::*;
#(
  parameter int         ROWS            = 4,
  parameter int         COLS            = 4,
  parameter int         SCAN_DIV        = 100000,
  parameter int         DEBOUNCE_FRAMES = 3,
  parameter int         NUM_DIGITS      = 4,
  parameter int         PMOD_MAP        = 1,
  parameter int         CLEAR_EN        = 1,
  parameter logic [3:0] CLEAR_CODE      = 4'hC
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ROWS-1:0]                 row,
  output logic [COLS-1:0]                 col,
  input  logic                            clear,
  output logic                            key_valid,
  output logic [3:0]                      key_code,
  output logic                            key_held,
  output logic [4*NUM_DIGITS-1:0]         digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0] count
);
  localparam int DW_W = idx_w(SCAN_DIV);
  localparam int CI_W = idx_w(COLS);
  localparam int RI_W = idx_w(ROWS);
  localparam int NC_W = $clog2(NUM_DIGITS + 1);

  logic [ROWS-1:0]         row_s1_q, row_s2_q;
  logic [DW_W-1:0]         dwell_q;
  logic [CI_W-1:0]         col_idx_q;
  logic [1:0]              acc_lows_q, acc_lows_d;
  logic [3:0]              acc_code_q, acc_code_d;
  logic [2:0]              lows_sum;
  logic [1:0]              smp_lows;
  logic [RI_W-1:0]         smp_row;
  logic [3:0]              smp_code;
  logic                    sample, last_col, frame_stb;
  frame_result_t           frame_res;
  logic                    accept;
  logic [3:0]              accept_code;
  logic                    key_valid_q;
  logic [3:0]              key_code_q;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NC_W-1:0]         count_q, count_d;

  assign sample    = (dwell_q == DW_W'(SCAN_DIV - 1));
  assign last_col  = (col_idx_q == CI_W'(COLS - 1));
  assign frame_stb = sample && last_col;
  assign col       = ~(COLS'(1) << col_idx_q);

  // Low-row count saturates at 2: anything beyond one pressed switch is MULTI.
  always_comb begin
    smp_lows = 2'd0;
    smp_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_s2_q[r]) begin
        if (smp_lows == 2'd0) smp_row = RI_W'(r);
        if (smp_lows != 2'd2) smp_lows = smp_lows + 2'd1;
      end
    end
    if (PMOD_MAP != 0) smp_code = PMOD_KEYMAP[4'(int'(smp_row) * 4 + int'(col_idx_q))];
    else               smp_code = 4'(int'(smp_row) * COLS + int'(col_idx_q));
    lows_sum   = {1'b0, acc_lows_q} + {1'b0, smp_lows};
    acc_lows_d = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
    acc_code_d = (acc_lows_q != 2'd0) ? acc_code_q : smp_code;
    case (acc_lows_d)
      2'd0:    frame_res = NONE;
      2'd1:    frame_res = KEY;
      default: frame_res = MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q   <= '1;
      row_s2_q   <= '1;
      dwell_q    <= '0;
      col_idx_q  <= '0;
      acc_lows_q <= 2'd0;
      acc_code_q <= 4'd0;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      if (sample) begin
        dwell_q    <= '0;
        col_idx_q  <= last_col ? '0 : col_idx_q + CI_W'(1);
        acc_lows_q <= last_col ? 2'd0 : acc_lows_d;
        acc_code_q <= last_col ? 4'd0 : acc_code_d;
      end else begin
        dwell_q <= dwell_q + DW_W'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (reset),
    .frame_stb_i  (frame_stb),
    .frame_res_i  (frame_res),
    .frame_code_i (acc_code_d),
    .accept_o     (accept),
    .accept_code_o(accept_code),
    .held_o       (key_held)
  );

  // The clear port overrides an accept in the same cycle; the event itself still fires.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (clear) begin
      digits_d = '0;
      count_d  = '0;
    end else if (accept) begin
      if ((CLEAR_EN != 0) && (accept_code == CLEAR_CODE)) begin
        digits_d = '0;
        count_d  = '0;
      end else begin
        digits_d      = digits_q << 4;
        digits_d[3:0] = accept_code;
        count_d       = (count_q == NC_W'(NUM_DIGITS)) ? count_q : count_q + NC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      digits_q    <= '0;
      count_q     <= '0;
    end else begin
      key_valid_q <= accept;
      if (accept) key_code_q <= accept_code;
      digits_q <= digits_d;
      count_q  <= count_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digits    = digits_q;
  assign count     = count_q;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed and randomized frame-level bench for keypad_entry_scanner against a key-set model.
module tb_keypad_entry_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DF       = 2;
  localparam int ND       = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] digits;
  logic [2:0]  count;
  logic [15:0] press_mask;

  int checks = 0;
  int errors = 0;
  int obs_pulses = 0;
  int m_cand, m_cnt, m_stable, m_dig, m_count, m_code, m_kv;
  int KMAP [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int sel, len, rc;
  logic [15:0] rm;

  keypad_entry_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF),
    .NUM_DIGITS(ND), .PMOD_MAP(1), .CLEAR_EN(1), .CLEAR_CODE(4'hC)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .clear(clear),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
    .digits(digits), .count(count)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed switch at (r,c) pulls row r low while column c is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (press_mask[r*4+c]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] kmask(input int code);
    logic [15:0] m;
    m = '0;
    for (int p = 0; p < 16; p++) if (KMAP[p] == code) m[p] = 1'b1;
    return m;
  endfunction

  // -1 = no key, -2 = several keys, otherwise the key code.
  function automatic int frame_val(input logic [15:0] m);
    int n;
    n = $countones(m);
    if (n == 0) return -1;
    if (n > 1) return -2;
    for (int p = 0; p < 16; p++) if (m[p]) return KMAP[p];
    return -2;
  endfunction

  task automatic model_reset();
    m_cand = -3; m_cnt = 0; m_stable = -1;
    m_dig = 0; m_count = 0; m_code = 0; m_kv = 0;
  endtask

  task automatic model_frame(input int v, input int clr_at);
    m_kv = 0;
    if (clr_at >= 0 && clr_at < 15) begin m_dig = 0; m_count = 0; end
    if (v == -2) begin
      m_cnt = 0; m_cand = -3;
    end else begin
      if (v == m_cand) m_cnt++;
      else begin m_cand = v; m_cnt = 1; end
      if (m_cnt >= DF && m_cand != m_stable) begin
        if (m_cand >= 0) begin
          m_kv = 1;
          m_code = m_cand;
          if (m_cand == 12) begin m_dig = 0; m_count = 0; end
          else begin
            m_dig = (m_dig * 16 + m_cand) % 65536;
            m_count = (m_count < ND) ? m_count + 1 : ND;
          end
        end
        m_stable = m_cand;
      end
    end
    if (clr_at == 15) begin m_dig = 0; m_count = 0; end
  endtask

  // Entered at a falling edge in the first cycle of a frame; leaves at the next frame's first cycle.
  task automatic run_frame(input logic [15:0] mask, input int clr_at);
    logic [3:0] ec;
    press_mask = mask;
    for (int i = 0; i < 16; i++) begin
      clear = (i == clr_at);
      ec = ~(4'b0001 << (i / 4));
      chk("col", col, ec);
      if (i > 0) chk("kv_quiet", key_valid, 0);
      @(posedge clk);
      @(negedge clk);
    end
    clear = 1'b0;
    model_frame(frame_val(mask), clr_at);
    if (key_valid === 1'b1) obs_pulses++;
    chk("key_valid", key_valid, m_kv);
    chk("key_code", key_code, m_code);
    chk("key_held", key_held, (m_stable >= 0) ? 1 : 0);
    chk("digits", digits, m_dig);
    chk("count", count, m_count);
  endtask

  task automatic hold(input logic [15:0] mask, input int n);
    for (int f = 0; f < n; f++) run_frame(mask, -1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; press_mask = '0;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", col, 4'hE);
    chk("rst_kv", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_held", key_held, 0);
    chk("rst_digits", digits, 0);
    chk("rst_count", count, 0);
    reset = 1'b1;
    model_reset();

    // Free-running scan with nothing pressed.
    hold(16'h0, 2);

    // Single key held, then released.
    hold(kmask(1), 5);
    chk("t2_pulses", obs_pulses, 1);
    chk("t2_digits", digits, 16'h0001);
    chk("t2_count", count, 1);
    chk("t2_held", key_held, 1);
    hold(16'h0, 3);
    chk("t2_rel_held", key_held, 0);
    chk("t2_rel_pulses", obs_pulses, 1);

    // Sequence entry with saturation.
    hold(kmask(2), 3);  hold(16'h0, 3);
    hold(kmask(3), 3);  hold(16'h0, 3);
    hold(kmask(10), 3); hold(16'h0, 3);
    hold(kmask(5), 3);  hold(16'h0, 3);
    chk("t3_digits", digits, 16'h23A5);
    chk("t3_count", count, 4);
    chk("t3_pulses", obs_pulses, 5);

    // Bounce and multi-key rejection.
    hold(kmask(1), 1); hold(16'h0, 3);
    hold(kmask(2) | kmask(3), 4);
    chk("t4_pulses", obs_pulses, 5);
    chk("t4_held", key_held, 0);
    hold(16'h0, 2);

    // Clear port, clear key, and clear coinciding with an accept.
    run_frame(16'h0, 5);
    hold(kmask(1), 3); hold(16'h0, 3);
    hold(kmask(2), 3); hold(16'h0, 3);
    chk("t5_digits12", digits, 16'h0012);
    hold(kmask(12), 3);
    chk("t5_clrkey_code", key_code, 4'hC);
    chk("t5_clrkey_digits", digits, 0);
    chk("t5_clrkey_count", count, 0);
    hold(16'h0, 3);
    hold(16'h0, 0);
    run_frame(kmask(1), -1); run_frame(kmask(1), -1);
    hold(16'h0, 3);
    run_frame(kmask(7), -1);
    run_frame(kmask(7), 15);
    chk("t5_coinc_kv", key_valid, 1);
    chk("t5_coinc_code", key_code, 7);
    chk("t5_coinc_digits", digits, 0);
    chk("t5_coinc_count", count, 0);
    hold(kmask(7), 1); hold(16'h0, 3);

    // Asynchronous reset mid-dwell while a key is held.
    hold(kmask(9), 3);
    chk("t6_held_before", key_held, 1);
    repeat (6) begin @(posedge clk); @(negedge clk); end
    reset = 1'b0;
    #1;
    chk("t6_col", col, 4'hE);
    chk("t6_kv", key_valid, 0);
    chk("t6_code", key_code, 0);
    chk("t6_held", key_held, 0);
    chk("t6_digits", digits, 0);
    chk("t6_count", count, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run_frame(kmask(9), -1);
    run_frame(kmask(9), -1);
    chk("t6_reaccept_kv", key_valid, 1);
    chk("t6_reaccept_code", key_code, 9);
    chk("t6_reaccept_digits", digits, 16'h0009);
    hold(16'h0, 3);

    // Randomized press patterns, durations and clear pulses.
    for (int s = 0; s < 30; s++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 4);
      if (sel < 2)      rm = 16'h0;
      else if (sel < 3) rm = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      else              rm = 16'h1 << $urandom_range(0, 15);
      for (int f = 0; f < len; f++) begin
        rc = $urandom_range(0, 9);
        run_frame(rm, (rc == 0) ? 15 : ((rc == 1) ? 7 : -1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_scanner.md
Name: keypad_entry_scanner

Overview:
Parametrised keypad front end for the Lab4 display path. It scans an ROWS x COLS matrix keypad with an active-low column strobe and debounces whole scan frames. Each new key press produces a one-cycle event and is shifted into an NUM_DIGITS-deep hex digit buffer that feeds the display. It adds multi-key rejection, a clear key/port, a held-key flag and an entry count.

Parameters:
ROWS, 4, keypad rows; ROWS*COLS <= 16
COLS, 4, keypad columns
SCAN_DIV, 100000, clk cycles each column is driven (1 ms at 100 MHz); >= 4
DEBOUNCE_FRAMES, 3, consecutive identical frames needed to accept a change; >= 1
NUM_DIGITS, 4, digit buffer depth
PMOD_MAP, 1, 1 = 4x4 Pmod KYPD legend (requires ROWS=COLS=4); 0 = code is row*COLS+col
CLEAR_EN, 1, 1 = a press of CLEAR_CODE clears the buffer instead of entering
CLEAR_CODE, 4'hC, key code that acts as clear

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
row  in  ROWS  keypad rows, active-low, asynchronous; 2-flop synchronised internally
col  out  COLS  column strobe; exactly one bit low at all times
clear  in  1  synchronous buffer clear, one cycle
key_valid  out  1  one-cycle pulse on each accepted new press
key_code  out  4  code of the last accepted key; held between pulses
key_held  out  1  high while the debounced state is "one key pressed"
digits  out  4*NUM_DIGITS  digit buffer; [3:0] is the newest digit
count  out  clog2(NUM_DIGITS+1)  digits entered, saturates at NUM_DIGITS

Behaviour:
- Reset (reset=0, async): col = ~1 (column 0 driven), column index 0, dwell counter 0, key_valid=0, key_code=0, key_held=0, digits=0, count=0, debounce counter 0, stable state = none.
- Scan: a dwell counter counts 0..SCAN_DIV-1 per column. The synchronised rows are sampled on dwell=SCAN_DIV-1. The column then advances, wrapping COLS-1 -> 0. One frame = COLS*SCAN_DIV cycles.
- Frame result is evaluated at the last sample of column COLS-1:
  - NONE: 0 rows low in every column.
  - KEY(code): exactly 1 row low in exactly 1 column.
  - MULTI: anything else.
- Code mapping for PMOD_MAP=1, row r / col c, row-major:
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = 0 F E D
- Debounce FSM:
  - States: IDLE (stable none), PRESSED (stable key).
  - Candidate register plus counter. Frame equals candidate -> counter++, else candidate = frame, counter = 1.
  - MULTI frame: counter = 0 and candidate invalidated; stable state is unchanged.
  - When counter reaches DEBOUNCE_FRAMES and candidate differs from stable, stable <= candidate.
  - IDLE -> PRESSED(k): accept event.
  - PRESSED(k) -> PRESSED(j), j != k: accept event.
  - PRESSED -> IDLE: no event.
- Accept event, registered in the cycle after the deciding sample:
  - key_valid=1 for exactly one cycle; key_code=k.
  - Holding a key never repeats the event.
- Buffer update, same cycle as key_valid:
  - If CLEAR_EN and k==CLEAR_CODE: digits=0, count=0.
  - Otherwise: digits <= {digits[4*NUM_DIGITS-5:0], k}, oldest digit dropped; count <= min(count+1, NUM_DIGITS).
- clear port: digits=0, count=0 next cycle. If clear coincides with an accept event, clear wins; key_valid and key_code still update.
- key_held is 1 exactly while stable is PRESSED.
- Minimum latency from a clean press to key_valid is DEBOUNCE_FRAMES complete frames plus synchroniser delay (2 cycles) plus 1 cycle.

Decomposition:
- Package keypad_pkg holds:
  - frame_result_t enum {NONE, KEY, MULTI};
  - the 16-entry PMOD_KEYMAP constant;
  - clog2-based width helpers.
- Sub-module keypad_debounce holds the candidate/counter/stable FSM and emits the accept event. It takes the frame result and code per frame strobe.
- Scan counters and the digit buffer stay in keypad_entry_scanner.

Test Plan:
All tests use SCAN_DIV=4, DEBOUNCE_FRAMES=2, NUM_DIGITS=4, PMOD_MAP=1, CLEAR_EN=1 (frame = 16 cycles).
1. Reset, then free-run 32 cycles -> col sequence E,D,B,7 repeating, each held 4 cycles; all outputs 0.
2. Hold row0 low whenever col=E (key "1") for 5 frames -> exactly one key_valid, key_code=1, digits=16'h0001, count=1, key_held=1. Release for 3 frames -> key_held=0, no pulse.
3. Press 1,2,3,A,5 in turn, each with release between -> digits=16'h23A5, count=4 (saturated), five key_valid pulses.
4. Press 1 for one frame only, then release (bounce) -> no key_valid; press 2 and 3 together for 4 frames -> MULTI, no key_valid, key_held unchanged.
5. With digits=16'h0012, press C -> key_valid with key_code=C, digits=0, count=0. Pulse clear in the accept cycle of key 7 -> digits=0, key_code=7.
6. Assert reset mid-dwell while key_held=1 -> col=E immediately, all outputs 0. Still-held key is re-accepted after 2 frames plus 3 cycles.
